// File: rtl/ldm_ctrl_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
// Beat size and FSM state encodings.
package ldm_ctrl_pkg;

  localparam int MEM_W = 4;

  typedef enum logic [1:0] {
    LDM_IDLE = 2'd0,
    LDM_XFER = 2'd1,
    LDM_DONE = 2'd2
  } ldm_state_e;

endpackage

// File: rtl/ldm_prio_enc.sv
// Register-list priority encoder: lowest set index, its one-hot clear mask, single-bit flag, popcount.
// Latency: combinational.
// Backpressure: none (pure function of the mask).
module ldm_prio_enc #(
  parameter int NREG = 16,
  parameter int IW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic [NREG-1:0] i_mask,
  output logic [IW-1:0]   o_idx,
  output logic [NREG-1:0] o_clr,
  output logic            o_single,
  output logic [CW-1:0]   o_cnt
);

  always_comb begin
    o_idx = '0;
    o_cnt = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = IW'(i);
    end
    for (int i = 0; i < NREG; i++) begin
      o_cnt = o_cnt + CW'(i_mask[i]);
    end
  end

  assign o_clr    = i_mask & (~i_mask + NREG'(1));
  assign o_single = (i_mask != '0) && ((i_mask & (i_mask - NREG'(1))) == '0);

endmodule

// File: rtl/ldm_ctrl.sv
// LDM/STM sequencer: walks the register list lowest-first, one memory beat per accepted handshake.
// Latency: request to first beat 1 cycle; N beats then one DONE cycle.
// Backpressure: i_mem_rdy low holds every beat output stable; IF/ID stays stalled.
module ldm_ctrl
  import ldm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NREG   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_is_ldm,
  input  logic              i_ldm_p,
  input  logic              i_ldm_u,
  input  logic              i_ldm_l,
  input  logic [NREG-1:0]   i_ldm_reglist,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_mem_rdy,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_mem_vld,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_reg_code,
  output logic              o_reg_vld,
  output logic              o_last,
  output logic              o_pc_load,
  output logic [ADDR_W-1:0] o_base_new,
  output logic              o_done
);

  localparam int CW = $clog2(NREG + 1);
  localparam logic [ADDR_W-1:0] BEAT = ADDR_W'(MEM_W);

  ldm_state_e        state;
  logic [NREG-1:0]   pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_new_q;
  logic              load_q;

  logic [NREG-1:0]   enc_in;
  logic [3:0]        enc_idx;
  logic [NREG-1:0]   enc_clr;
  logic              enc_single;
  logic [CW-1:0]     enc_cnt;

  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] base_next;
  logic              xfer;

  // One encoder serves both phases: popcount of the request in IDLE, pending-mask walk in XFER.
  assign enc_in = (state == LDM_IDLE) ? i_ldm_reglist : pend_q;

  ldm_prio_enc #(
    .NREG (NREG)
  ) u_enc (
    .i_mask   (enc_in),
    .o_idx    (enc_idx),
    .o_clr    (enc_clr),
    .o_single (enc_single),
    .o_cnt    (enc_cnt)
  );

  // Beats always ascend, so descending modes start at the bottom of the block.
  always_comb begin
    span = ADDR_W'(enc_cnt) << 2;
    base_next = i_ldm_u ? (i_base + span) : (i_base - span);
    case ({i_ldm_p, i_ldm_u})
      2'b01:   start_addr = i_base;
      2'b11:   start_addr = i_base + BEAT;
      2'b00:   start_addr = i_base - span + BEAT;
      default: start_addr = i_base - span;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= LDM_IDLE;
      pend_q     <= '0;
      addr_q     <= '0;
      base_new_q <= '0;
      load_q     <= 1'b0;
    end else begin
      case (state)
        LDM_IDLE: begin
          if (i_is_ldm) begin
            base_new_q <= base_next;
            if (i_ldm_reglist != '0) begin
              pend_q <= i_ldm_reglist;
              load_q <= i_ldm_l;
              addr_q <= start_addr;
              state  <= LDM_XFER;
            end else begin
              state <= LDM_DONE;
            end
          end
        end
        LDM_XFER: begin
          if (i_mem_rdy) begin
            pend_q <= pend_q & ~enc_clr;
            addr_q <= addr_q + BEAT;
            if (enc_single) state <= LDM_DONE;
          end
        end
        LDM_DONE: state <= LDM_IDLE;
        default:  state <= LDM_IDLE;
      endcase
    end
  end

  assign xfer       = (state == LDM_XFER);
  assign o_stall    = ((state == LDM_IDLE) && i_is_ldm) || xfer;
  assign o_busy     = (state != LDM_IDLE);
  assign o_mem_vld  = xfer;
  assign o_reg_vld  = xfer;
  assign o_mem_we   = xfer && !load_q;
  assign o_mem_addr = xfer ? addr_q : '0;
  assign o_reg_code = xfer ? enc_idx : 4'd0;
  assign o_last     = xfer && enc_single;
  assign o_pc_load  = o_last && load_q && (enc_idx == 4'd15);
  assign o_base_new = base_new_q;
  assign o_done     = (state == LDM_DONE);

endmodule

// File: tb/tb_ldm_ctrl.sv
// Self-checking bench for ldm_ctrl: directed scenarios plus randomized requests against a list/arithmetic model.
module tb_ldm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_ldm, p, u, l;
  logic [15:0] reglist;
  logic [31:0] base;
  logic        rdy;

  logic        o_stall, o_busy, o_mem_vld, o_mem_we, o_reg_vld, o_last, o_pc_load, o_done;
  logic [31:0] o_mem_addr, o_base_new;
  logic [3:0]  o_reg_code;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ldm_ctrl #(.ADDR_W(32), .NREG(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_is_ldm      (is_ldm),
    .i_ldm_p       (p),
    .i_ldm_u       (u),
    .i_ldm_l       (l),
    .i_ldm_reglist (reglist),
    .i_base        (base),
    .i_mem_rdy     (rdy),
    .o_stall       (o_stall),
    .o_busy        (o_busy),
    .o_mem_vld     (o_mem_vld),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_reg_code    (o_reg_code),
    .o_reg_vld     (o_reg_vld),
    .o_last        (o_last),
    .o_pc_load     (o_pc_load),
    .o_base_new    (o_base_new),
    .o_done        (o_done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_stall"}, o_stall, 1'b0);
    chk1({tag, "_busy"}, o_busy, 1'b0);
    chk1({tag, "_vld"}, o_mem_vld, 1'b0);
    chk1({tag, "_we"}, o_mem_we, 1'b0);
    chk32({tag, "_addr"}, o_mem_addr, 32'h0);
    chk32({tag, "_code"}, 32'(o_reg_code), 32'h0);
    chk1({tag, "_regvld"}, o_reg_vld, 1'b0);
    chk1({tag, "_last"}, o_last, 1'b0);
    chk1({tag, "_pcload"}, o_pc_load, 1'b0);
    chk32({tag, "_basenew"}, o_base_new, 32'h0);
    chk1({tag, "_done"}, o_done, 1'b0);
  endtask

  // Issues one request from IDLE and checks every beat against the expected transfer list.
  task automatic run_req(input logic rp, input logic ru, input logic rl, input logic [15:0] rlist,
                         input logic [31:0] rbase, input int hold0, input bit rnd, input bit chain);
    int          regs[$];
    int          n, k, cyc;
    logic [31:0] span, lo, bnew;
    logic        r, lastb;
    regs = {};
    for (int i = 0; i < 16; i++) if (rlist[i]) regs.push_back(i);
    n    = regs.size();
    span = 32'(4 * n);
    bnew = ru ? rbase + span : rbase - span;
    lo   = ru ? rbase + (rp ? 32'd4 : 32'd0) : rbase - span + (rp ? 32'd0 : 32'd4);

    is_ldm = 1'b1; p = rp; u = ru; l = rl; reglist = rlist; base = rbase; rdy = 1'b0;
    #1;
    chk1("req_stall", o_stall, 1'b1);
    chk1("req_busy", o_busy, 1'b0);
    @(posedge clk); #1;
    is_ldm  = 1'b0;
    reglist = 16'($urandom);
    base    = $urandom;

    k = 0; cyc = 0;
    while (k < n && cyc < 64) begin
      r = (cyc < hold0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      rdy = r;
      #1;
      lastb = (k == n - 1);
      chk1("beat_vld", o_mem_vld, 1'b1);
      chk1("beat_regvld", o_reg_vld, 1'b1);
      chk32("beat_code", 32'(o_reg_code), 32'(regs[k]));
      chk32("beat_addr", o_mem_addr, lo + 32'(4 * k));
      chk1("beat_last", o_last, lastb);
      chk1("beat_we", o_mem_we, !rl);
      chk1("beat_pcload", o_pc_load, lastb && rl && (regs[k] == 15));
      chk1("beat_stall", o_stall, 1'b1);
      chk1("beat_done", o_done, 1'b0);
      chk32("beat_basenew", o_base_new, bnew);
      @(posedge clk); #1;
      if (r) k++;
      cyc++;
    end
    chk32("beat_count", 32'(k), 32'(n));
    rdy = 1'b0;
    chk1("done_pulse", o_done, 1'b1);
    chk1("done_vld", o_mem_vld, 1'b0);
    chk1("done_stall", o_stall, 1'b0);
    chk1("done_busy", o_busy, 1'b1);
    chk32("done_basenew", o_base_new, bnew);
    if (!chain) begin
      @(posedge clk); #1;
      chk1("idle_done", o_done, 1'b0);
      chk1("idle_busy", o_busy, 1'b0);
      chk32("idle_basenew", o_base_new, bnew);
    end
  endtask

  logic [15:0] lst;

  initial begin
    rst = 1'b1; is_ldm = 1'b0; p = 1'b0; u = 1'b0; l = 1'b0;
    reglist = 16'h0; base = 32'h0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(1'b0, 1'b1, 1'b1, 16'h000B, 32'h0000_1000, 0, 1'b0, 1'b0);  // IA load
    run_req(1'b1, 1'b0, 1'b0, 16'h8001, 32'h0000_2000, 0, 1'b0, 1'b0);  // DB store
    run_req(1'b1, 1'b1, 1'b1, 16'h8000, 32'h0000_0100, 0, 1'b0, 1'b0);  // IB load R15
    run_req(1'b0, 1'b0, 1'b1, 16'h0006, 32'h0000_0040, 2, 1'b0, 1'b0);  // DA with backpressure
    run_req(1'b0, 1'b1, 1'b1, 16'h0000, 32'h0000_0500, 0, 1'b0, 1'b0);  // empty list
    run_req(1'b0, 1'b1, 1'b0, 16'h00FF, 32'hFFFF_FFF8, 0, 1'b1, 1'b0);  // address wrap

    // A request presented during DONE is ignored and accepted the following cycle.
    run_req(1'b0, 1'b1, 1'b1, 16'h0003, 32'h0000_0080, 0, 1'b0, 1'b1);
    is_ldm = 1'b1; p = 1'b1; u = 1'b0; l = 1'b0; reglist = 16'h0C00; base = 32'h0000_3000;
    #1;
    chk1("chain_done_stall", o_stall, 1'b0);
    chk1("chain_done_pulse", o_done, 1'b1);
    @(posedge clk); #1;
    chk1("chain_idle_busy", o_busy, 1'b0);
    chk1("chain_idle_done", o_done, 1'b0);
    run_req(1'b1, 1'b0, 1'b0, 16'h0C00, 32'h0000_3000, 0, 1'b1, 1'b0);

    // Reset during beat 2 of 4 abandons the transfer.
    is_ldm = 1'b1; p = 1'b0; u = 1'b1; l = 1'b1; reglist = 16'h00F0; base = 32'h0000_0800;
    @(posedge clk); #1;
    is_ldm = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk32("mid_code", 32'(o_reg_code), 32'd5);
    chk32("mid_addr", o_mem_addr, 32'h0000_0804);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    run_req(1'b0, 1'b1, 1'b1, 16'h00F0, 32'h0000_0800, 0, 1'b0, 1'b0);

    repeat (40) begin
      case ($urandom_range(0, 3))
        0:       lst = 16'h0;
        1:       lst = 16'h1 << $urandom_range(0, 15);
        default: lst = 16'($urandom);
      endcase
      run_req(1'($urandom), 1'($urandom), 1'($urandom), lst, $urandom & 32'hFFFF_FFFC,
              int'($urandom_range(0, 2)), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
